bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 7-segment cathode decoder. It turns a W-bit unsigned binary value into four registered BCD digits (ones, tens, hundreds, thousands) using iterative shift-and-add-3 (double dabble), one bit per clock. The digit decoder then only indexes a digit by the refresh counter instead of performing `%`/divide arithmetic. A start/ready/done handshake is used, and the previous result stays stable on the outputs until a new conversion completes.

## Interface
- `W`, default 14: input width in bits; legal range 4..14.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `bin`  in  W  unsigned value; captured only when a start is accepted.
- `start`  in  1  request a conversion; accepted only while `ready`=1.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  single-cycle pulse; the new result is on the outputs in the same cycle.
- `d0`, `d1`, `d2`, `d3`  out  4 each  BCD ones, tens, hundreds and thousands digits; registered.
- `ovf`  out  1  set when the captured value exceeded 9999; registered with the digits.

## Operation
- FSM states and transitions:
  - IDLE: `ready`=1. On `start`=1, capture `bin` into the shift register, clear the BCD scratch (16 bits), load the bit counter with W, latch the overflow condition (`bin` > 9999), and go to SHIFT.
  - SHIFT: each cycle, first add 3 to every scratch nibble that is ≥ 5, then shift {scratch, shreg} left by 1 and decrement the counter. When the counter reaches 1 on an active cycle, go to DONE. SHIFT lasts exactly W cycles.
  - DONE: load `d0`–`d3` from scratch and `ovf` from the latched flag, pulse `done`, return to IDLE.
- Overflow: if the latched flag is set, DONE loads 9, 9, 9, 9 and sets `ovf`=1; otherwise `ovf`=0. The conversion still runs the full W cycles, so latency is constant.
- Scratch width is fixed at 16 bits. Any bit shifted out of the thousands nibble is discarded; this only happens for values > 9999, which are already flagged.
- `start` outside IDLE is ignored and not queued. `bin` changes after capture have no effect.
- Outputs `d*` and `ovf` change only in DONE; between conversions they hold the last result.
- Reset (`rst_n`=0 at a clock edge), including mid-SHIFT or in DONE: state becomes IDLE, and `d0`–`d3` = 0, `ovf`=0, `done`=0, scratch/counter = 0. The conversion in flight is abandoned with no `done` pulse. After release, `ready`=1 on the first cycle.

## Timing
- Start accepted at edge k. SHIFT covers edges k+1 … k+W. The DONE state is entered after edge k+W; `done`=1 and the new digits are visible during that cycle.
- Latency from the accepting edge to `done` high: W+1 cycles (15 for W=14).
- `ready` drops the cycle after acceptance and returns the cycle after `done`.
- Minimum start-to-start spacing: W+2 cycles.
- All outputs are registered. There is no combinational path from `start` or `bin` to any output.

## Structure
- Shared package `seg_pkg`:
  - state enum {IDLE, SHIFT, DONE};
  - constants: `NDIG`=4, `BCDW`=4, `BCD_MAX`=9999;
  - the 7-bit segment pattern constants, shared with the cathode decoder.
- One natural sub-module: `bcd_digit_adj`, purely combinational, 4-bit in/out, add-3-if-≥5. It is instantiated four times over the scratch nibbles.

## Test plan
- `bin`=0, start → `done` 15 cycles after acceptance; d3..d0 = 0,0,0,0; `ovf`=0.
- `bin`=1234 → d3..d0 = 1,2,3,4; `ovf`=0. Then `bin`=9999 → 9,9,9,9, `ovf`=0. Check the outputs hold 1,2,3,4 throughout the second conversion until its `done`.
- `bin`=10000 and `bin`=16383 → d3..d0 = 9,9,9,9; `ovf`=1. Then `bin`=7 → 0,0,0,7 with `ovf` cleared.
- Pulse `start` with `bin`=42, then pulse `start` again 3 cycles later with `bin`=99 → exactly one `done`, with the result 0,0,4,2. `ready`=0 for 15 cycles.
- Assert `rst_n`=0 for one cycle at SHIFT cycle 6 of a 5678 conversion → no `done`; outputs all 0; `ready`=1 the next cycle. A fresh start with 5678 then yields 5,6,7,8.
- Hold `start`=1 continuously with `bin`=305 → a `done` pulse every 16 cycles, each with the result 0,3,0,5.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display path: converter FSM
// states, BCD sizing and the cathode segment patterns (gfedcba, active high).
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NDIG    = 4;
    localparam int BCDW    = 4;
    localparam int BCD_MAX = 9999;
    localparam int SCRW    = NDIG * BCDW;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-BCD codes blank the digit rather than show garbage.
    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import seg_pkg::*;
(
    input  logic [BCDW-1:0] din,
    output logic [BCDW-1:0] dout
);

    // add-3 correction
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with start/ready/done handshake and registered, held digit outputs.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] bin,
    input  logic         start,
    output logic         ready,
    output logic         done,
    output logic [3:0]   d0,
    output logic [3:0]   d1,
    output logic [3:0]   d2,
    output logic [3:0]   d3,
    output logic         ovf
);

    localparam int CNTW = 4;

    state_t            state_r;
    state_t            state_s;
    logic [W-1:0]      shreg_r;
    logic [SCRW-1:0]   scratch_r;
    logic [SCRW-1:0]   adj_s;
    logic [SCRW:0]     shifted_s;
    logic [SCRW-1:0]   result_s;
    logic [CNTW-1:0]   cnt_r;
    logic              ovf_flag_r;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_r[i*BCDW +: BCDW]),
            .dout (adj_s[i*BCDW +: BCDW])
        );
    end

    // The bit falling off the thousands nibble only appears for inputs above
    // 9999; it is folded into the overflow flag instead of being dropped.
    assign shifted_s = {adj_s, shreg_r[W-1]};

    // next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == 4'd1) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // result selection: saturate to 9999 on overflow
    always_comb begin
        result_s = shifted_s[SCRW-1:0];
        if (ovf_flag_r) begin
            result_s = {NDIG{4'd9}};
        end else begin
            result_s = shifted_s[SCRW-1:0];
        end
    end

    // state, handshake, datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ready      <= 1'b1;
            done       <= 1'b0;
            shreg_r    <= '0;
            scratch_r  <= '0;
            cnt_r      <= '0;
            ovf_flag_r <= 1'b0;
            d0         <= 4'd0;
            d1         <= 4'd0;
            d2         <= 4'd0;
            d3         <= 4'd0;
            ovf        <= 1'b0;
        end else begin
            state_r <= state_s;
            ready   <= (state_s == IDLE);
            done    <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shreg_r    <= bin;
                        scratch_r  <= '0;
                        cnt_r      <= CNTW'(W);
                        ovf_flag_r <= (32'(bin) > 32'(BCD_MAX));
                    end
                end
                SHIFT: begin
                    shreg_r    <= {shreg_r[W-2:0], 1'b0};
                    scratch_r  <= shifted_s[SCRW-1:0];
                    cnt_r      <= cnt_r - 4'd1;
                    ovf_flag_r <= ovf_flag_r | shifted_s[SCRW];
                    // Final shift: publish so digits and done appear together.
                    if (cnt_r == 4'd1) begin
                        {d3, d2, d1, d0} <= result_s;
                        ovf              <= ovf_flag_r;
                    end
                end
                DONE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: accepted starts push decimal expectations,
// a monitor checks done results, latency, ready and output hold each cycle.
module tb_bin2bcd_seq;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] bin = '0;
    logic         ready;
    logic         done;
    logic [3:0]   d0, d1, d2, d3;
    logic         ovf;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [16:0] exp_q[$];
    int          lat_q[$];
    int          acc_cyc = -100;
    int          busy_end = -100;
    logic [16:0] cur_exp = '0;

    bin2bcd_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (bin),
        .start (start),
        .ready (ready),
        .done  (done),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .d3    (d3),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [16:0] model(input int v);
        if (v > 9999) return {1'b1, 4'd9, 4'd9, 4'd9, 4'd9};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // stimulus-side scoreboard feed: record every accepted start
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_end <= (busy_end < cyc) ? busy_end : cyc;
        end else if (start && ready) begin
            exp_q.push_back(model(int'(bin)));
            lat_q.push_back(cyc);
            acc_cyc  <= cyc;
            busy_end <= cyc + W + 1;
        end
    end

    // monitor: compare whatever the DUT presents
    always @(negedge clk) begin
        logic [16:0] act;
        logic [16:0] e;
        int          c;
        if (cyc > 0) begin
            act = {ovf, d3, d2, d1, d0};
            chk("ready", 32'(ready), (cyc > acc_cyc && cyc <= busy_end) ? 32'd0 : 32'd1);
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 with result %0h, expected no done (cycle %0d)", act, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = lat_q.pop_front();
                    chk("result", 32'(act), 32'(e));
                    chk("latency", 32'(cyc - c), 32'(W + 1));
                    cur_exp = e;
                end
            end else begin
                chk("hold", 32'(act), 32'(cur_exp));
            end
            if (!rst_n) begin
                exp_q.delete();
                lat_q.delete();
                cur_exp = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 100) begin
            step();
            t++;
        end
        if (!ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got ready=0, expected ready=1 within 100 cycles");
        end
    endtask

    task automatic convert(input int v);
        wait_ready();
        bin   = W'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        bin   = W'($urandom_range(0, 16383));
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !ready) && t < 200) begin
            step();
            t++;
        end
        if (exp_q.size() != 0 || !ready) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending, expected 0 within 200 cycles", exp_q.size());
        end
    endtask

    initial begin
        repeat (3) step();
        rst_n = 1'b1;
        step();

        convert(0);
        convert(1234);
        convert(9999);
        convert(10000);
        convert(16383);
        convert(7);
        drain();

        // second start 3 cycles later must be ignored
        wait_ready();
        bin   = W'(42);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        bin   = W'(99);
        start = 1'b1;
        step();
        start = 1'b0;
        drain();

        // reset sampled at SHIFT cycle 6 abandons the conversion
        convert(5678);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        convert(5678);
        drain();

        // back-to-back conversions with start held high
        bin   = W'(305);
        start = 1'b1;
        repeat (70) step();
        start = 1'b0;
        drain();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) step();
            if ($urandom_range(0, 1) == 0) convert($urandom_range(0, 9999));
            else convert($urandom_range(0, 16383));
        end
        drain();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
